// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: counts refresh ticks, takes the command bus
// from the main arbiter, issues PRECHARGE ALL followed by one or more
// back-to-back AUTO REFRESH commands, and then releases the bus.
module sdram_refresh_sched #(
  parameter int TrpCycles    = 3,
  parameter int TrfcCycles   = 9,
  parameter int MaxPending   = 8,
  parameter int UrgentThresh = 4
) (
  input  logic                              i_dram_clk,
  input  logic                              i_rst_n,
  input  logic                              i_init_done,
  input  logic                              i_refresh_req,
  input  logic                              i_bus_grant,
  output logic                              o_refresh_en,
  output logic                              o_bus_req,
  output logic                              o_urgent,
  output logic [3:0]                        o_cmd,
  output logic                              o_a10,
  output logic                              o_ref_done,
  output logic [$clog2(MaxPending+1)-1:0]   o_pending,
  output logic                              o_overflow
);

  localparam int PW   = $clog2(MaxPending + 1);
  localparam int WMAX = (TrpCycles > TrfcCycles) ? TrpCycles : TrfcCycles;
  localparam int CW   = $clog2(WMAX + 1);

  localparam logic [3:0]    CMD_NOP  = 4'b0111;
  localparam logic [3:0]    CMD_PRE  = 4'b0010;
  localparam logic [3:0]    CMD_REF  = 4'b0001;
  localparam logic [CW-1:0] RP_LOAD  = CW'(TrpCycles - 1);
  localparam logic [CW-1:0] RFC_LOAD = CW'(TrfcCycles - 1);
  localparam logic [CW-1:0] WAIT_ONE = CW'(1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MaxPending);
  localparam logic [PW-1:0] URG_TH   = PW'(UrgentThresh);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_PRE, ST_WAIT_RP, ST_REF, ST_WAIT_RFC
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          ren_q;
  logic          inc, dec;
  logic [3:0]    cmd;
  logic          a10, bus_req, ref_done;

  // Pending-refresh bookkeeping; forced to zero until init completes.
  always_comb begin
    inc    = i_refresh_req;
    dec    = (state_q == ST_REF) && (pend_q != '0);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (!i_init_done) begin
      pend_d = '0;
    end else if (inc && !dec) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Sequence FSM; one down-counter times both tRP and tRFC waits.
  // The end-of-tRFC decision looks at the post-update count so a tick
  // landing in that last cycle still earns a back-to-back refresh.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cmd      = CMD_NOP;
    a10      = 1'b0;
    bus_req  = 1'b1;
    ref_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_req = 1'b0;
        if (i_init_done && (pend_q != '0)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_bus_grant) state_d = ST_PRE;
      end
      ST_PRE: begin
        cmd = CMD_PRE;
        a10 = 1'b1;
        if (TrpCycles > 1) begin
          state_d = ST_WAIT_RP;
          wait_d  = RP_LOAD;
        end else begin
          state_d = ST_REF;
        end
      end
      ST_WAIT_RP: begin
        if (wait_q <= WAIT_ONE) begin
          state_d = ST_REF;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_REF: begin
        cmd = CMD_REF;
        if (TrfcCycles > 1) begin
          state_d = ST_WAIT_RFC;
          wait_d  = RFC_LOAD;
        end else if (pend_d != '0) begin
          state_d = ST_REF;
        end else begin
          state_d  = ST_IDLE;
          ref_done = 1'b1;
        end
      end
      ST_WAIT_RFC: begin
        if (wait_q <= WAIT_ONE) begin
          wait_d = '0;
          if (pend_d != '0) begin
            state_d = ST_REF;
          end else begin
            state_d  = ST_IDLE;
            ref_done = 1'b1;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bus_req = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any sequence in flight.
  always_ff @(posedge i_dram_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ren_q   <= i_init_done;
    end
  end

  assign o_refresh_en = ren_q;
  assign o_bus_req    = bus_req;
  assign o_cmd        = cmd;
  assign o_a10        = a10;
  assign o_ref_done   = ref_done;
  assign o_pending    = pend_q;
  assign o_overflow   = ovf_q;
  assign o_urgent     = (pend_q >= URG_TH);

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Bench for sdram_refresh_sched: directed scenarios plus a randomized run
// checked against a timestamp-based reference model.
module tb_sdram_refresh_sched;
  localparam int TRP = 3, TRFC = 9, MAXP = 8, URG = 4;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001;

  logic clk = 1'b0, rst_n = 1'b0, init = 1'b0, tick = 1'b0, grant = 1'b0;
  logic ren, bus_req, urgent, a10, ref_done, ovf;
  logic [3:0] cmd;
  logic [3:0] pending;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sdram_refresh_sched dut (
    .i_dram_clk(clk), .i_rst_n(rst_n), .i_init_done(init),
    .i_refresh_req(tick), .i_bus_grant(grant),
    .o_refresh_en(ren), .o_bus_req(bus_req), .o_urgent(urgent),
    .o_cmd(cmd), .o_a10(a10), .o_ref_done(ref_done),
    .o_pending(pending), .o_overflow(ovf)
  );

  // Reference model: mode 0 idle, 1 asking for bus, 2 sequence running.
  // Commands are predicted as absolute cycle numbers.
  int cyc = 0, m_mode = 0, m_pre = 0, m_ref = 0, m_pend = 0;
  bit m_ovf = 0, m_en = 0;

  function automatic int next_pend(int p, bit t, bit in, bit isref);
    bit d;
    d = isref && (p > 0);
    if (!in) return 0;
    if (t && !d) return (p == MAXP) ? p : p + 1;
    if (d && !t) return p - 1;
    return p;
  endfunction

  function automatic logic [3:0] m_cmd(int c);
    if (m_mode == 2 && c == m_pre) return PRE;
    if (m_mode == 2 && c == m_ref) return REF;
    return NOP;
  endfunction

  initial forever begin
    int np;
    logic [3:0] mc;
    @(posedge clk);
    mc = m_cmd(cyc);
    np = next_pend(m_pend, tick, init, mc == REF);
    if (!rst_n) begin
      m_mode = 0; m_pend = 0; m_ovf = 0; m_en = 0;
    end else begin
      if (init && tick && m_pend == MAXP && mc != REF) m_ovf = 1;
      case (m_mode)
        0: if (init && m_pend > 0) m_mode = 1;
        1: if (grant) begin m_mode = 2; m_pre = cyc + 1; m_ref = cyc + 1 + TRP; end
        default: if (cyc == m_ref + TRFC - 1) begin
          if (np > 0) m_ref = m_ref + TRFC;
          else m_mode = 0;
        end
      endcase
      m_pend = np;
      m_en = init;
    end
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; init = 1'b0; tick = 1'b0; grant = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init = 1'b1; tick = 1'b1; grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      total++;
      if ({bus_req, ref_done, a10, ovf, ren, urgent, pending, cmd} !== {6'b0, 4'd0, NOP}) begin
        bad++;
        $display("FAIL reset[%0d]: got %b want %b", i,
                 {bus_req, ref_done, a10, ovf, ren, urgent, pending, cmd}, {6'b0, 4'd0, NOP});
      end
    end
    step();
    rst_n = 1'b1; tick = 1'b0; grant = 1'b0; init = 1'b0;
  endtask

  task automatic test_init_low();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick = (i % 4 == 1);
      @(negedge clk);
      total++;
      if (pending !== 4'd0 || bus_req !== 1'b0 || cmd !== NOP) begin
        bad++;
        $display("FAIL init_low[%0d]: pend=%0d req=%b cmd=%b want 0 0 0111", i, pending, bus_req, cmd);
      end
      step();
    end
    tick = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] tc[20];
    logic ta[20], td[20], tb[20];
    int tp[20];
    bit seen;
    apply_reset();
    init = 1'b1;
    @(negedge clk);
    total++;
    if (ren !== 1'b0) begin bad++; $display("FAIL refresh_en_lag: got %b want 0", ren); end
    step();
    @(negedge clk);
    total++;
    if (ren !== 1'b1) begin bad++; $display("FAIL refresh_en_on: got %b want 1", ren); end
    step();
    tick = 1'b1; step(); tick = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 4'd1) begin bad++; $display("FAIL single_pend: got %0d want 1", pending); end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL single_busreq: got 0 want 1 within 10 cycles"); end
    step(); step();
    grant = 1'b1; step(); grant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tc[i] = cmd; ta[i] = a10; td[i] = ref_done; tb[i] = bus_req; tp[i] = int'(pending);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ec;
      logic ea, ed, eb;
      int ep;
      ec = (i == 0) ? PRE : (i == 3) ? REF : NOP;
      ea = (i == 0); ed = (i == 11); eb = (i < 12); ep = (i < 4) ? 1 : 0;
      total++;
      if (tc[i] !== ec || ta[i] !== ea || td[i] !== ed || tb[i] !== eb || tp[i] != ep) begin
        bad++;
        $display("FAIL single_seq[%0d]: got cmd=%b a10=%b done=%b req=%b pend=%0d want %b %b %b %b %0d",
                 i, tc[i], ta[i], td[i], tb[i], tp[i], ec, ea, ed, eb, ep);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tc[40];
    logic td[40], tb[40];
    int refs[$];
    int npre, prei, ndone, donei, rel;
    apply_reset();
    init = 1'b1; step();
    for (int j = 0; j < 3; j++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    @(negedge clk);
    total++;
    if (pending !== 4'd3 || bus_req !== 1'b1) begin
      bad++; $display("FAIL b2b_pend: got pend=%0d req=%b want 3 1", pending, bus_req);
    end
    step();
    grant = 1'b1; step(); grant = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tc[i] = cmd; td[i] = ref_done; tb[i] = bus_req;
      step();
    end
    npre = 0; prei = -1; ndone = 0; donei = -1; rel = -1;
    for (int i = 0; i < 40; i++) begin
      if (tc[i] === PRE) begin npre++; prei = i; end
      if (tc[i] === REF) refs.push_back(i);
      if (td[i] === 1'b1) begin ndone++; donei = i; end
      if (rel < 0 && tb[i] === 1'b0) rel = i;
    end
    total++;
    if (npre != 1 || prei != 0) begin bad++; $display("FAIL b2b_pre: got n=%0d at %0d want 1 at 0", npre, prei); end
    total++;
    if (refs.size() != 3) begin
      bad++; $display("FAIL b2b_nref: got %0d want 3", refs.size());
    end else begin
      total++;
      if (refs[0] != TRP || refs[1] - refs[0] != TRFC || refs[2] - refs[1] != TRFC) begin
        bad++; $display("FAIL b2b_spacing: got %0d %0d %0d want 3 12 21", refs[0], refs[1], refs[2]);
      end
      total++;
      if (ndone != 1 || donei != refs[2] + TRFC - 1 || rel != refs[2] + TRFC) begin
        bad++; $display("FAIL b2b_done: got n=%0d at %0d rel=%0d want 1 at %0d rel=%0d",
                        ndone, donei, rel, refs[2] + TRFC - 1, refs[2] + TRFC);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    init = 1'b1; step();
    tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      int ep;
      step();
      if (k == 9) tick = 1'b0;
      @(negedge clk);
      ep = (k > MAXP) ? MAXP : k;
      total++;
      if (int'(pending) != ep || urgent !== (ep >= URG) || ovf !== (k > MAXP)) begin
        bad++;
        $display("FAIL saturate[%0d]: got pend=%0d urg=%b ovf=%b want %0d %b %b",
                 k, pending, urgent, ovf, ep, (ep >= URG), (k > MAXP));
      end
    end
    repeat (3) step();
    @(negedge clk);
    total++;
    if (ovf !== 1'b1 || pending !== 4'd8) begin
      bad++; $display("FAIL overflow_sticky: got ovf=%b pend=%0d want 1 8", ovf, pending);
    end
  endtask

  task automatic test_coincident();
    logic [3:0] tc[30];
    logic td[30];
    int tp[30];
    bit seen;
    int nref, ndone;
    apply_reset();
    init = 1'b1; step();
    tick = 1'b1; step(); tick = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL coinc_busreq: got 0 want 1 within 10 cycles"); end
    step();
    grant = 1'b1; step(); grant = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick = (i == 3);
      @(negedge clk);
      tc[i] = cmd; td[i] = ref_done; tp[i] = int'(pending);
      step();
    end
    tick = 1'b0;
    nref = 0; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (tc[i] === REF) nref++;
      if (td[i] === 1'b1) ndone++;
    end
    total++;
    if (tp[3] != 1 || tp[4] != 1 || tp[13] != 0) begin
      bad++; $display("FAIL coinc_pend: got %0d %0d %0d want 1 1 0", tp[3], tp[4], tp[13]);
    end
    total++;
    if (tc[3] !== REF || tc[12] !== REF || nref != 2) begin
      bad++; $display("FAIL coinc_ref: got cmd3=%b cmd12=%b n=%0d want 0001 0001 2", tc[3], tc[12], nref);
    end
    total++;
    if (td[20] !== 1'b1 || td[11] !== 1'b0 || ndone != 1) begin
      bad++; $display("FAIL coinc_done: got d11=%b d20=%b n=%0d want 0 1 1", td[11], td[20], ndone);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    init = 1'b1; step();
    tick = 1'b1; repeat (9) step(); tick = 1'b0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL mid_preovf: got %b want 1", ovf); end
    step();
    grant = 1'b1; step(); grant = 1'b0;
    repeat (6) step();
    @(negedge clk);
    total++;
    if (cmd !== NOP || bus_req !== 1'b1) begin
      bad++; $display("FAIL mid_inwait: got cmd=%b req=%b want 0111 1", cmd, bus_req);
    end
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_req, ref_done, a10, ovf, ren, urgent, pending, cmd} !== {6'b0, 4'd0, NOP}) begin
      bad++;
      $display("FAIL mid_reset: got %b want %b",
               {bus_req, ref_done, a10, ovf, ren, urgent, pending, cmd}, {6'b0, 4'd0, NOP});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      total++;
      if (cmd !== NOP || bus_req !== 1'b0) begin
        bad++; $display("FAIL mid_quiet[%0d]: got cmd=%b req=%b want 0111 0", i, cmd, bus_req);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    init = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] ec;
      logic ed;
      int np;
      logic [13:0] expv, actv;
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 79) == 0) init = ~init;
      tick  = ($urandom_range(0, 4) == 0);
      grant = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      ec = m_cmd(cyc);
      np = next_pend(m_pend, tick, init, ec == REF);
      ed = (m_mode == 2) && (cyc == m_ref + TRFC - 1) && (np == 0);
      expv = {(m_mode != 0), ed, (ec == PRE), m_ovf, m_en, (m_pend >= URG), 4'(m_pend), ec};
      actv = {bus_req, ref_done, a10, ovf, ren, urgent, pending, cmd};
      total++;
      if (actv !== expv) begin
        bad++;
        $display("FAIL random[%0d]: got %b want %b (req,done,a10,ovf,en,urg,pend,cmd)", n, actv, expv);
      end
      step();
    end
    tick = 1'b0; grant = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_init_low();
    test_single();
    test_back_to_back();
    test_saturate();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
